// File: rtl/chunk_proto_pkg.sv
// rtl/chunk_proto_pkg.sv - GPIO chunk protocol constants and host FSM encoding.
package chunk_proto_pkg;

  localparam logic [31:0] CTRL_HOLD  = 32'd0;
  localparam logic [31:0] CTRL_START = 32'd1;
  localparam logic [31:0] CTRL_CLEAR = 32'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LOC_WR_BIT     = 31;
  localparam int NUM_IN_CHUNKS  = 8;
  localparam int MUL_OUT_CHUNKS = 8;
  localparam int DIV_OUT_CHUNKS = 4;

  localparam logic [31:0] LOC_WR = 32'h1 << LOC_WR_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_COLLECT,
    S_CLEAR,
    S_FINISH,
    S_ABORT
  } host_state_t;

  // Input chunk k: 0-3 come from A, 4-7 from B, least significant word first.
  function automatic logic [31:0] in_chunk(input logic [127:0] a, input logic [127:0] b,
                                           input logic [2:0] k);
    if (k[2]) return b[{k[1:0], 5'b0} +: 32];
    else      return a[{k[1:0], 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/mult_div_host_if.sv
// rtl/mult_div_host_if.sv - GPIO port bundle between the host and the arithmetic unit.
interface mult_div_host_if;
  logic [31:0] select;
  logic [31:0] in_loc;
  logic [31:0] in_val;
  logic [31:0] ctrl_reg;
  logic [31:0] out_loc;
  logic [31:0] out_val;
  logic [31:0] state_reg;

  modport master (
    output select, in_loc, in_val, ctrl_reg,
    input  out_loc, out_val, state_reg
  );

  modport slave (
    input  select, in_loc, in_val, ctrl_reg,
    output out_loc, out_val, state_reg
  );
endinterface

// File: rtl/mult_div_host_chunk_collector.sv
// rtl/mult_div_host_chunk_collector.sv - result chunk register file with capture mask.
module chunk_collector
  import chunk_proto_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         capture,
  input  logic         div_mode,
  input  logic [3:0]   idx,
  input  logic [31:0]  data,
  output logic [255:0] result,
  output logic         complete
);

  logic [7:0] mask;
  logic [7:0] mask_nxt;
  logic [7:0] need;
  logic       wr_en;

  // Divide only owns chunks 0-3; writes to 4-7 are dropped so they stay zero.
  always_comb begin
    need     = div_mode ? 8'((1 << DIV_OUT_CHUNKS) - 1) : 8'((1 << MUL_OUT_CHUNKS) - 1);
    wr_en    = capture && !idx[3] && need[idx[2:0]];
    mask_nxt = mask;
    if (wr_en) mask_nxt[idx[2:0]] = 1'b1;
    complete = capture && ((mask_nxt & need) == need);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask   <= '0;
      result <= '0;
    end else if (clear) begin
      mask   <= '0;
      result <= '0;
    end else if (wr_en) begin
      mask                            <= mask_nxt;
      result[{idx[2:0], 5'b0} +: 32]  <= data;
    end
  end

endmodule

// File: rtl/mult_div_host.sv
// rtl/mult_div_host.sv - serializes operands to the mult/div unit and gathers its result.
module mult_div_host
  import chunk_proto_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sel,
  input  logic [127:0]     op_a,
  input  logic [127:0]     op_b,
  output logic             busy,
  output logic [255:0]     result,
  output logic             result_valid,
  output logic             error,
  mult_div_host_if.master  bus
);

  host_state_t  state;
  logic [127:0] a_q;
  logic [127:0] b_q;
  logic         op_q;
  logic [3:0]   ld_idx;
  logic [15:0]  tmo_cnt;
  logic [31:0]  in_loc_q;
  logic [31:0]  in_val_q;
  logic [31:0]  ctrl_q;
  logic         complete;
  logic         unit_done;
  logic         unit_idle;
  logic         unused_bits;

  assign unit_done   = (bus.state_reg[1:0] == ST_DONE);
  assign unit_idle   = (bus.state_reg[1:0] == ST_IDLE);
  assign unused_bits = ^{bus.state_reg[31:2], bus.out_loc[31:4]};

  assign bus.select   = {31'b0, op_q};
  assign bus.in_loc   = in_loc_q;
  assign bus.in_val   = in_val_q;
  assign bus.ctrl_reg = ctrl_q;

  chunk_collector u_collector (
    .clk      (clk_fpga),
    .rst      (reset),
    .clear    (state == S_IDLE && start),
    .capture  (state == S_COLLECT && unit_done),
    .div_mode (op_q),
    .idx      (bus.out_loc[3:0]),
    .data     (bus.out_val),
    .result   (result),
    .complete (complete)
  );

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      ld_idx       <= '0;
      tmo_cnt      <= '0;
      in_loc_q     <= '0;
      in_val_q     <= '0;
      ctrl_q       <= CTRL_HOLD;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      error        <= 1'b0;
      case (state)
        // Chunk 0 goes out on the accepting edge so the eight writes are back to back.
        S_IDLE: if (start) begin
          a_q      <= op_a;
          b_q      <= op_b;
          op_q     <= op_sel;
          in_loc_q <= LOC_WR;
          in_val_q <= op_a[31:0];
          ld_idx   <= 4'd1;
          busy     <= 1'b1;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          if (ld_idx == 4'(NUM_IN_CHUNKS)) begin
            in_loc_q <= '0;
            in_val_q <= '0;
            ctrl_q   <= CTRL_START;
            state    <= S_START;
          end else begin
            in_loc_q <= LOC_WR | 32'(ld_idx);
            in_val_q <= in_chunk(a_q, b_q, ld_idx[2:0]);
            ld_idx   <= ld_idx + 4'd1;
          end
        end
        S_START: begin
          ctrl_q  <= CTRL_HOLD;
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (unit_done) begin
            state <= S_COLLECT;
          end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
            ctrl_q <= CTRL_CLEAR;
            state  <= S_ABORT;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_COLLECT: if (complete) begin
          ctrl_q <= CTRL_CLEAR;
          state  <= S_CLEAR;
        end
        S_CLEAR: if (unit_idle) begin
          ctrl_q       <= CTRL_HOLD;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_FINISH;
        end
        S_FINISH: state <= S_IDLE;
        S_ABORT: if (unit_idle) begin
          ctrl_q <= CTRL_HOLD;
          error  <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_host.sv
// tb/tb_mult_div_host.sv - directed bench for mult_div_host with a behavioural unit responder.
module tb_mult_div_host;

  logic         clk_fpga = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_sel = 1'b0;
  logic [127:0] op_a = '0;
  logic [127:0] op_b = '0;
  logic         busy;
  logic [255:0] result;
  logic         result_valid;
  logic         error;

  int passed = 0;
  int total  = 0;

  mult_div_host_if bus();

  mult_div_host #(.TIMEOUT(16)) dut (
    .clk_fpga     (clk_fpga),
    .reset        (reset),
    .start        (start),
    .op_sel       (op_sel),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .bus          (bus)
  );

  always #5 clk_fpga = ~clk_fpga;

  // Unit model: captures written chunks, computes on start, replays result chunks in seq order.
  int           r_state = 0;
  int           r_delay = 3;
  bit           r_stuck = 0;
  int           r_wait = 0;
  bit           r_hold = 0;
  int           r_pos = 0;
  int           clear_pos = -1;
  logic [31:0]  r_chunks [8];
  logic [255:0] r_res = '0;
  int           seq_idx [$];
  bit           seq_bad [$];

  task automatic drive_chunk();
    int i;
    logic [31:0] v;
    i = seq_idx[r_pos];
    v = (i < 8) ? r_res[i*32 +: 32] : 32'hBAD0_0009;
    if (seq_bad[r_pos]) v = v ^ 32'hDEAD_BEEF;
    bus.out_loc = 32'(i);
    bus.out_val = v;
  endtask

  always @(negedge clk_fpga or posedge reset) begin
    if (reset) begin
      r_state = 0;
      bus.state_reg = 0;
      bus.out_loc = 0;
      bus.out_val = 0;
    end else begin
      case (r_state)
        0: begin
          if (bus.in_loc[31]) r_chunks[bus.in_loc[2:0]] = bus.in_val;
          if (bus.ctrl_reg == 32'd1) begin
            logic [127:0] a, b;
            a = {r_chunks[3], r_chunks[2], r_chunks[1], r_chunks[0]};
            b = {r_chunks[7], r_chunks[6], r_chunks[5], r_chunks[4]};
            if (bus.select[0]) r_res = {128'b0, a[63:0] % b[63:0], a[63:0] / b[63:0]};
            else               r_res = {128'b0, a} * {128'b0, b};
            bus.state_reg = 1;
            r_wait = r_delay;
            r_state = 1;
          end
        end
        1: begin
          if (bus.ctrl_reg == 32'd2) begin
            bus.state_reg = 0;
            r_state = 0;
          end else if (!r_stuck) begin
            if (r_wait > 0) r_wait--;
            else begin
              r_state = 2;
              bus.state_reg = 2;
              r_pos = 0;
              r_hold = 1;
              drive_chunk();
            end
          end
        end
        default: begin
          if (bus.ctrl_reg == 32'd2) begin
            clear_pos = r_pos;
            bus.state_reg = 0;
            r_state = 0;
          end else if (r_hold) begin
            r_hold = 0;
          end else begin
            if (r_pos < seq_idx.size() - 1) r_pos++;
            drive_chunk();
          end
        end
      endcase
    end
  end

  task automatic set_seq_inorder();
    seq_idx = '{0, 1, 2, 3, 4, 5, 6, 7};
    seq_bad = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic issue(input logic sel, input logic [127:0] a, input logic [127:0] b);
    @(negedge clk_fpga);
    op_sel = sel;
    op_a = a;
    op_b = b;
    start = 1'b1;
    clear_pos = -1;
    @(negedge clk_fpga);
    start = 1'b0;
  endtask

  task automatic watch(input int max_cyc, output int rv_n, output int err_n,
                       output int end_cyc, output logic busy_end);
    rv_n = 0;
    err_n = 0;
    end_cyc = -1;
    busy_end = 1'bx;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk_fpga);
      if (result_valid) rv_n++;
      if (error) err_n++;
      if ((result_valid || error) && end_cyc < 0) begin
        end_cyc = cyc;
        busy_end = busy;
      end
      if (end_cyc >= 0 && cyc >= end_cyc + 4) break;
    end
  endtask

  task automatic wait_ctrl1(output bit found);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.ctrl_reg == 32'd1) found = 1;
      else @(negedge clk_fpga);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    op_a = '1;
    op_b = '1;
    repeat (3) @(negedge clk_fpga);
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++; if ({result_valid, error} !== 2'b00) $display("FAIL rst_pulses: got %b expected 00", {result_valid, error}); else passed++;
    total++; if (bus.in_loc !== 32'd0) $display("FAIL rst_in_loc: got %h expected 0", bus.in_loc); else passed++;
    total++; if ({bus.in_val, bus.ctrl_reg, bus.select} !== 96'd0) $display("FAIL rst_unit_out: got %h expected 0", {bus.in_val, bus.ctrl_reg, bus.select}); else passed++;
    total++; if (result !== 256'd0) $display("FAIL rst_result: got %h expected 0", result); else passed++;
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk_fpga);
    total++; if (busy !== 1'b0 || bus.in_loc !== 32'd0) $display("FAIL rst_release: busy=%b in_loc=%h expected 0/0", busy, bus.in_loc); else passed++;
  endtask

  task automatic test_multiply();
    int rv_n, err_n, end_cyc;
    logic busy_end;
    logic [255:0] exp;
    exp = {127'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};
    set_seq_inorder();
    r_delay = 3;
    r_stuck = 0;
    issue(1'b0, {128{1'b1}}, 128'd2);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk_fpga);
      total++; if (bus.in_loc !== (32'h8000_0000 | 32'(k))) $display("FAIL mul_load_%0d: got %h expected %h", k, bus.in_loc, 32'h8000_0000 | 32'(k)); else passed++;
    end
    @(negedge clk_fpga);
    total++; if (bus.ctrl_reg !== 32'd1 || bus.in_loc !== 32'd0) $display("FAIL mul_start: ctrl=%h in_loc=%h expected 1/0", bus.ctrl_reg, bus.in_loc); else passed++;
    @(negedge clk_fpga);
    total++; if (bus.ctrl_reg !== 32'd0) $display("FAIL mul_start_once: got %h expected 0", bus.ctrl_reg); else passed++;
    total++; if (busy !== 1'b1 || bus.select !== 32'd0) $display("FAIL mul_busy_sel: busy=%b select=%h expected 1/0", busy, bus.select); else passed++;
    watch(60, rv_n, err_n, end_cyc, busy_end);
    total++; if (rv_n !== 1 || err_n !== 0) $display("FAIL mul_pulses: rv=%0d err=%0d expected 1/0", rv_n, err_n); else passed++;
    total++; if (result !== exp) $display("FAIL mul_result: got %h expected %h", result, exp); else passed++;
    total++; if (busy_end !== 1'b0) $display("FAIL mul_busy_fall: got %b expected 0", busy_end); else passed++;
    total++; if (clear_pos !== 7) $display("FAIL mul_clear_pos: got %0d expected 7", clear_pos); else passed++;
  endtask

  task automatic test_divide();
    int rv_n, err_n, end_cyc;
    logic busy_end;
    seq_idx = '{0, 5, 1, 2, 3};
    seq_bad = '{0, 1, 0, 0, 0};
    r_delay = 3;
    r_stuck = 0;
    issue(1'b1, 128'd100, 128'd7);
    total++; if (bus.select !== 32'd1) $display("FAIL div_select: got %h expected 1", bus.select); else passed++;
    watch(60, rv_n, err_n, end_cyc, busy_end);
    total++; if (rv_n !== 1 || err_n !== 0) $display("FAIL div_pulses: rv=%0d err=%0d expected 1/0", rv_n, err_n); else passed++;
    total++; if (result[63:0] !== 64'd14) $display("FAIL div_quo: got %0d expected 14", result[63:0]); else passed++;
    total++; if (result[127:64] !== 64'd2) $display("FAIL div_rem: got %0d expected 2", result[127:64]); else passed++;
    total++; if (result[255:128] !== 128'd0) $display("FAIL div_upper: got %h expected 0", result[255:128]); else passed++;
    total++; if (clear_pos !== 4) $display("FAIL div_clear_pos: got %0d expected 4", clear_pos); else passed++;
  endtask

  task automatic test_out_of_order();
    int rv_n, err_n, end_cyc;
    logic busy_end;
    logic [127:0] b;
    logic [255:0] exp;
    b = 128'h0000_0005_0000_0000_0000_0000_0000_0007;
    exp = {b, 128'd0} >> 64;
    seq_idx = '{7, 0, 7, 3, 9, 1, 2, 4, 5, 6};
    seq_bad = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    r_delay = 3;
    r_stuck = 0;
    issue(1'b0, 128'h1_0000_0000_0000_0000, b);
    watch(60, rv_n, err_n, end_cyc, busy_end);
    total++; if (rv_n !== 1 || err_n !== 0) $display("FAIL ooo_pulses: rv=%0d err=%0d expected 1/0", rv_n, err_n); else passed++;
    total++; if (result !== exp) $display("FAIL ooo_result: got %h expected %h", result, exp); else passed++;
    total++; if (clear_pos !== 9) $display("FAIL ooo_clear_pos: got %0d expected 9", clear_pos); else passed++;
  endtask

  task automatic test_timeout();
    bit found;
    int t_clr, t_err, rv_n, err_n;
    logic busy_err;
    set_seq_inorder();
    r_stuck = 1;
    t_clr = -1;
    t_err = -1;
    rv_n = 0;
    err_n = 0;
    busy_err = 1'bx;
    issue(1'b0, 128'd3, 128'd4);
    wait_ctrl1(found);
    total++; if (!found) $display("FAIL tmo_start: ctrl_reg=1 not seen, got %h", bus.ctrl_reg); else passed++;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk_fpga);
      if (bus.ctrl_reg == 32'd2 && t_clr < 0) t_clr = t;
      if (error && t_err < 0) begin
        t_err = t;
        busy_err = busy;
      end
      if (error) err_n++;
      if (result_valid) rv_n++;
    end
    r_stuck = 0;
    total++; if (t_clr !== 17) $display("FAIL tmo_clear_cycle: got %0d expected 17", t_clr); else passed++;
    total++; if (t_err !== 18) $display("FAIL tmo_error_cycle: got %0d expected 18", t_err); else passed++;
    total++; if (err_n !== 1 || rv_n !== 0) $display("FAIL tmo_pulses: err=%0d rv=%0d expected 1/0", err_n, rv_n); else passed++;
    total++; if (busy_err !== 1'b0) $display("FAIL tmo_busy_fall: got %b expected 0", busy_err); else passed++;
  endtask

  task automatic test_start_ignored();
    bit found;
    int rv_n, err_n, end_cyc, extra;
    logic busy_end;
    set_seq_inorder();
    r_delay = 10;
    r_stuck = 0;
    issue(1'b0, 128'd6, 128'd7);
    wait_ctrl1(found);
    repeat (3) @(negedge clk_fpga);
    op_sel = 1'b1;
    op_a = 128'd1;
    op_b = 128'd1;
    start = 1'b1;
    @(negedge clk_fpga);
    start = 1'b0;
    watch(60, rv_n, err_n, end_cyc, busy_end);
    total++; if (rv_n !== 1 || err_n !== 0) $display("FAIL ign_pulses: rv=%0d err=%0d expected 1/0", rv_n, err_n); else passed++;
    total++; if (result !== 256'd42) $display("FAIL ign_result: got %h expected 42", result); else passed++;
    total++; if (bus.select !== 32'd0) $display("FAIL ign_select: got %h expected 0", bus.select); else passed++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_fpga);
      if (busy || bus.ctrl_reg == 32'd1) extra++;
    end
    total++; if (extra !== 0) $display("FAIL ign_no_queue: busy/start cycles=%0d expected 0", extra); else passed++;
    r_delay = 3;
  endtask

  task automatic test_async_reset();
    int rv_n, err_n, end_cyc;
    logic busy_end;
    bit seen;
    set_seq_inorder();
    r_delay = 3;
    r_stuck = 0;
    issue(1'b0, 128'd3, 128'd5);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_fpga);
      if (bus.state_reg == 32'd2) seen = 1;
    end
    repeat (3) @(negedge clk_fpga);
    total++; if (!seen || busy !== 1'b1) $display("FAIL ar_pre: done_seen=%0d busy=%b expected 1/1", seen, busy); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if ({busy, result_valid, error} !== 3'b000) $display("FAIL ar_flags: got %b expected 000", {busy, result_valid, error}); else passed++;
    total++; if ({bus.in_loc, bus.in_val, bus.ctrl_reg, bus.select} !== 128'd0) $display("FAIL ar_unit_out: got %h expected 0", {bus.in_loc, bus.in_val, bus.ctrl_reg, bus.select}); else passed++;
    total++; if (result !== 256'd0) $display("FAIL ar_result: got %h expected 0", result); else passed++;
    @(negedge clk_fpga);
    reset = 1'b0;
    issue(1'b0, 128'd9, 128'd9);
    total++; if (bus.in_loc !== 32'h8000_0000) $display("FAIL ar_restart_load: got %h expected 80000000", bus.in_loc); else passed++;
    watch(60, rv_n, err_n, end_cyc, busy_end);
    total++; if (rv_n !== 1 || err_n !== 0) $display("FAIL ar_restart_pulses: rv=%0d err=%0d expected 1/0", rv_n, err_n); else passed++;
    total++; if (result !== 256'd81) $display("FAIL ar_restart_result: got %h expected 81", result); else passed++;
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_out_of_order();
    test_timeout();
    test_start_ignored();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/mult_div_host.md
# mult_div_host

Hardware initiator for the GPIO chunk protocol used by the 128-bit multiplier / 64-bit divider unit. It accepts a full-width operand pair and an operation select on a parallel start/done handshake, then serializes the operands into 32-bit chunks and issues start. It waits for completion, gathers the result chunks, and clears the unit. This lets RTL drive the arithmetic unit directly, in place of MCS firmware on the GPIO ports.

## Interface
- TIMEOUT, 1024: max cycles in WAIT before abort; 16-bit counter, legal range 2..65535.
- clk_fpga  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op_sel  in  1  0 = multiply, 1 = divide.
- op_a  in  128  operand A; divide uses [63:0].
- op_b  in  128  operand B; divide uses [63:0].
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- result  out  256  product, or {64'b0, 64'b0, remainder[127:64]=rem, quotient[63:0]=quo} for divide; held until next accepted start.
- result_valid  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on timeout abort.
- select  out  32  to unit; {31'b0, latched op_sel}.
- in_loc  out  32  to unit; [31] = write strobe, [3:0] = chunk index (0-3 A, 4-7 B).
- in_val  out  32  to unit; chunk data.
- ctrl_reg  out  32  to unit; 0 = hold, 1 = start, 2 = clear.
- out_loc  in  32  from unit; [3:0] = result chunk index.
- out_val  in  32  from unit; result chunk data.
- state_reg  in  32  from unit; [1:0]: 0 = idle, 1 = busy, 2 = done.

## Operation
- IDLE: when start=1, latch op_a, op_b, op_sel; clear the capture mask and result; go to LOAD.
- LOAD: 8 cycles, k = 0..7. Drive in_loc = 0x8000_0000 | k and in_val = chunk k (A[32k+31:32k] for k<4, B[32(k-4)+31:32(k-4)] for k≥4). Divide still writes all 8 chunks; upper chunks are taken from op_a/op_b as given. Then go to START.
- START: ctrl_reg = 1 for exactly one cycle, in_loc = 0. Reset the timeout counter. Go to WAIT.
- WAIT: ctrl_reg = 0. When state_reg[1:0]=2, go to COLLECT. When the counter reaches TIMEOUT-1 with no done, go to ABORT.
- COLLECT: each cycle state_reg=2, write out_val into result chunk out_loc[3:0] and set mask bit.
  - Duplicate indices overwrite the chunk.
  - Indices ≥8 are ignored.
  - Chunks needed: mult = 8 (0-7); div = 4 (0-3, result[127:0]); chunks 4-7 forced to 0.
  - When the mask is complete, including the chunk captured this cycle, go to CLEAR.
- CLEAR: ctrl_reg = 2 until state_reg=0, then go to FINISH. No timeout applies here.
- FINISH: pulse result_valid, go to IDLE.
- ABORT: ctrl_reg = 2 until state_reg=0. Pulse error and go to IDLE. result is left partial and is not signalled valid.
- start is ignored outside IDLE; it is not queued.
- Reset, at any time including mid-transaction: state to IDLE; busy, result_valid, error, in_loc, in_val, ctrl_reg, select to 0; result, latches, mask and counter to 0. The unit is not cleared by this block on reset; it shares the same reset.

## Timing
- All outputs are registered; unit inputs are sampled on the rising edge.
- start accepted at edge E. in_loc write k is visible in cycles E+1+k. ctrl_reg=1 is visible in cycle E+9.
- The first possible COLLECT sample is the cycle after the unit's state_reg=2 is seen.
- result_valid asserts 1 cycle after state_reg=0 is seen in CLEAR. result is stable from that cycle on.
- busy falls in the same cycle result_valid or error pulses.
- Timeout: error fires TIMEOUT + (clear handshake) + 1 cycles after START.

## Structure
- Package chunk_proto_pkg holds:
  - CTRL_HOLD/CTRL_START/CTRL_CLEAR
  - ST_IDLE/ST_BUSY/ST_DONE
  - LOC_WR_BIT = 31
  - NUM_IN_CHUNKS = 8, MUL_OUT_CHUNKS = 8, DIV_OUT_CHUNKS = 4
  - the FSM state encoding
- One sub-module, chunk_collector: the mask plus result register file with an index decoder. The FSM, serializer and timeout counter stay in mult_div_host.

## Test plan
- Reset: hold reset with start=1 → all outputs 0, no in_loc strobe; release → IDLE, busy=0.
- Multiply: A = 2^128-1, B = 2, behavioural responder → in_loc 0x8000_0000..0x8000_0007 on consecutive cycles, one ctrl_reg=1 cycle, then result = 2^129-2 and a single result_valid.
- Divide: op_sel=1, A=100, B=7 → select=1, result[63:0]=14, result[127:64]=2, result[255:128]=0.
- Out-of-order collect: responder emits out_loc 7,0,7,3,9,1,2,4,5,6 → index 9 ignored, chunk 7 takes its last value; done only after all 8 indices; result correct.
- Timeout: TIMEOUT=16, responder stuck busy → ctrl_reg=2 issued at WAIT cycle 16; error pulses once state_reg=0; result_valid never asserts.
- Mid-operation: start during WAIT is ignored; async reset during COLLECT → all outputs 0 immediately, without waiting for a clock edge; a new start after reset runs a clean transaction.
